// File: rtl/alu_pkg.sv
// Shared types for the ALU shift sequencer.
// Holds the shift direction and sequencer state encodings.
package alu_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit-per-clock shift register with load and step controls.
// Rotate fill exists only when SHIFT_CTRL_ROTATE_EN is defined.
module shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  dir_e             dir,
    input  logic             rot,
    output logic [WIDTH-1:0] q
);

    logic             fill_l;
    logic             fill_r;
    logic [WIDTH-1:0] nxt;

`ifdef SHIFT_CTRL_ROTATE_EN
    assign fill_l = rot & q[WIDTH-1];
    assign fill_r = rot & q[0];
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign fill_l     = 1'b0;
    assign fill_r     = 1'b0;
`endif

    always_comb begin
        nxt = q;
        unique case (dir)
            DIR_LEFT:  nxt = {q[WIDTH-2:0], fill_l};
            DIR_RIGHT: nxt = {fill_r, q[WIDTH-1:1]};
            default:   nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// Two-port round-robin arbiter and sequencer for the serial shifter.
// Optional rotate support: define SHIFT_CTRL_ROTATE_EN.
module shift_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_dir,
    input  logic [1:0]           req_rot,
    input  logic [2*SHAMT_W-1:0] req_shamt,
    input  logic [2*WIDTH-1:0]   req_a,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [WIDTH-1:0]     rsp_y
);

    state_e             state;
    state_e             state_nxt;
    logic [SHAMT_W-1:0] cnt;
    logic               last_grant;
    logic               cur_id;
    dir_e               cur_dir;
    logic               cur_rot;

    logic [1:0]         grant;
    logic               accept;
    logic               sel;
    logic [WIDTH-1:0]   a_sel;
    logic [SHAMT_W-1:0] shamt_sel;
    logic               load;
    logic               step;
    logic [WIDTH-1:0]   q;

    // Tie goes to the requester that did not win last time.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            unique case (req_valid)
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel       = grant[1];
    assign a_sel     = req_a[sel*WIDTH +: WIDTH];
    assign shamt_sel = req_shamt[sel*SHAMT_W +: SHAMT_W];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    state_nxt = (shamt_sel == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == SHAMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            cur_dir    <= DIR_LEFT;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt        <= shamt_sel;
                last_grant <= sel;
                cur_id     <= sel;
                cur_dir    <= dir_e'(req_dir[sel]);
            end else if (step) begin
                cnt <= cnt - SHAMT_W'(1);
            end
        end
    end

`ifdef SHIFT_CTRL_ROTATE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_rot <= 1'b0;
        end else if (load) begin
            cur_rot <= req_rot[sel];
        end
    end
`else
    logic [1:0] unused_req_rot;
    assign unused_req_rot = req_rot;
    assign cur_rot        = 1'b0;
`endif

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(a_sel),
        .step    (step),
        .dir     (cur_dir),
        .rot     (cur_rot),
        .q       (q)
    );

    assign rsp_valid = (state == DONE);
    assign rsp_y     = q;
    assign rsp_id    = cur_id;

endmodule

// File: tb/tb_shift_ctrl.sv
// Randomised self-checking bench for shift_ctrl.
// Reference model shifts with integer arithmetic and tracks round-robin.
module tb_shift_ctrl;

    localparam int W  = 4;
    localparam int SW = 3;
`ifdef SHIFT_CTRL_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [1:0]    req_dir = '0;
    logic [1:0]    req_rot = '0;
    logic [2*SW-1:0] req_shamt = '0;
    logic [2*W-1:0]  req_a = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id;
    logic [W-1:0]  rsp_y;

    int checks = 0;
    int passed = 0;
    bit last = 1'b1;

    always #5 clk = ~clk;

    shift_ctrl #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_dir  (req_dir),
        .req_rot  (req_rot),
        .req_shamt(req_shamt),
        .req_a    (req_a),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_y    (rsp_y)
    );

    function automatic logic [W-1:0] model(int a, bit dir, bit rot, int sh);
        int v = a;
        bit r = rot && ROT_EN;
        for (int i = 0; i < sh; i++) begin
            if (!dir) v = ((v * 2) % 16) + (r ? v / 8 : 0);
            else      v = (v / 2) + (r ? (v % 2) * 8 : 0);
        end
        return v[W-1:0];
    endfunction

    task automatic scramble();
        req_valid = 2'($urandom);
        req_dir   = 2'($urandom);
        req_rot   = 2'($urandom);
        req_shamt = 6'($urandom);
        req_a     = 8'($urandom);
    endtask

    task automatic op(input logic [1:0] v, input logic [3:0] a0,
                      input logic [3:0] a1, input logic [1:0] d,
                      input logic [1:0] r, input logic [2:0] s0,
                      input logic [2:0] s1, input int hold);
        bit g;
        int lat;
        int sh;
        logic [3:0] ea;
        logic [3:0] exp_y;
        logic [3:0] held;
        g = (v == 2'b11) ? ~last : (v == 2'b10);
        ea = g ? a1 : a0;
        sh = g ? int'(s1) : int'(s0);
        exp_y = model(int'(ea), d[g], r[g], sh);
        @(negedge clk);
        req_valid = v; req_a = {a1, a0}; req_dir = d;
        req_rot = r; req_shamt = {s1, s0};
        #1;
        checks++;
        if (req_ready !== (g ? 2'b10 : 2'b01))
            $display("FAIL grant: req_ready=%b want %b", req_ready, g ? 2'b10 : 2'b01);
        else passed++;
        last = g;
        @(posedge clk);
        #1 scramble();
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            checks++;
            if (req_ready !== 2'b00)
                $display("FAIL busy_ready: req_ready=%b want 00", req_ready);
            else passed++;
            @(posedge clk);
            #1 scramble();
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat !== sh + 1 || rsp_valid !== 1'b1)
            $display("FAIL latency: got %0d valid=%b want %0d", lat, rsp_valid, sh + 1);
        else passed++;
        checks++;
        if (rsp_y !== exp_y || rsp_id !== g)
            $display("FAIL result: y=%b id=%b want y=%b id=%b", rsp_y, rsp_id, exp_y, g);
        else passed++;
        held = rsp_y;
        for (int i = 0; i < hold; i++) begin
            scramble();
            req_valid = 2'b11;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_y !== held || req_ready !== 2'b00)
                $display("FAIL hold: valid=%b y=%b ready=%b want 1 %b 00",
                         rsp_valid, rsp_y, req_ready, held);
            else passed++;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0)
            $display("FAIL rsp_drop: rsp_valid=%b want 0", rsp_valid);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_y !== 4'b0 || rsp_id !== 1'b0 || req_ready !== 2'b00)
            $display("FAIL reset: valid=%b y=%b id=%b ready=%b want 0 0000 0 00",
                     rsp_valid, rsp_y, rsp_id, req_ready);
        else passed++;
        rst = 1'b1;
        last = 1'b1;
    endtask

    task automatic test_directed();
        op(2'b01, 4'b1010, 4'b0000, 2'b00, 2'b00, 3'd1, 3'd0, 0);
        op(2'b10, 4'b0000, 4'b1101, 2'b10, 2'b00, 3'd0, 3'd2, 0);
        op(2'b01, 4'b0110, 4'b0000, 2'b00, 2'b00, 3'd0, 3'd0, 5);
        op(2'b01, 4'b1111, 4'b0000, 2'b00, 2'b00, 3'd5, 3'd0, 0);
        op(2'b01, 4'b1000, 4'b0000, 2'b00, 2'b01, 3'd1, 3'd0, 0);
        op(2'b01, 4'b1001, 4'b0000, 2'b01, 2'b01, 3'd7, 3'd0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            op(2'b11, 4'($urandom), 4'($urandom), 2'($urandom),
               2'($urandom), 3'($urandom), 3'($urandom), 0);
    endtask

    task automatic test_random();
        logic [1:0] v;
        for (int i = 0; i < 40; i++) begin
            v = 2'($urandom_range(1, 3));
            op(v, 4'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
               3'($urandom), 3'($urandom), $urandom_range(0, 2));
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        req_valid = 2'b01; req_a = 8'h0B; req_shamt = {3'd0, 3'd6};
        req_dir = 2'b00; req_rot = 2'b00;
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_y !== 4'b0 || rsp_id !== 1'b0 || req_ready !== 2'b00)
            $display("FAIL mid_reset: valid=%b y=%b id=%b ready=%b want 0 0000 0 00",
                     rsp_valid, rsp_y, rsp_id, req_ready);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0)
                $display("FAIL stale_rsp: rsp_valid=%b want 0", rsp_valid);
            else passed++;
        end
        op(2'b10, 4'b0000, 4'b0111, 2'b10, 2'b00, 3'd0, 3'd1, 0);
        op(2'b11, 4'b0011, 4'b0101, 2'b00, 2'b00, 3'd2, 3'd2, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
